// File: rtl/z80mini_pkg.sv
// Shared definitions for the z80mini interrupt controller: register map,
// spurious-vector index and acknowledge state encoding.
package z80mini_pkg;

    localparam logic [1:0] REG_MASK = 2'd0;
    localparam logic [1:0] REG_PEND = 2'd1;
    localparam logic [1:0] REG_ISR  = 2'd2;
    localparam logic [1:0] REG_BASE = 2'd3;

    localparam logic [2:0] SPURIOUS_IDX = 3'd7;

    typedef enum logic [1:0] {
        ACK_IDLE = 2'd0,
        ACK_ACK  = 2'd1,
        ACK_HOLD = 2'd2
    } ack_state_t;

endpackage

// File: rtl/z80_int_ctrl_if.sv
// CPU-side bus of the interrupt controller: requests, acknowledge, I/O
// register port and the IM2 vector.
interface z80_int_ctrl_if #(
    parameter int unsigned NUM_SRC = 4
);
    logic [NUM_SRC-1:0] irq;
    logic               n_inta;
    logic               io_wr;
    logic               io_rd;
    logic [1:0]         addr;
    logic [7:0]         din;
    logic [7:0]         dout;
    logic               n_int;
    logic [7:0]         vec;

    modport master (
        output irq, n_inta, io_wr, io_rd, addr, din,
        input  dout, n_int, vec
    );

    modport slave (
        input  irq, n_inta, io_wr, io_rd, addr, din,
        output dout, n_int, vec
    );
endinterface

// File: rtl/z80_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any request is set
// and the index of the lowest one.
module z80_prio_enc #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] req,
    output logic         found,
    output logic [2:0]   idx
);
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (req[i] && !found) begin
                found = 1'b1;
                idx   = 3'(i);
            end
        end
    end
endmodule

// File: rtl/z80_int_ctrl.sv
// Prioritising IM2 interrupt controller: synchronises requests, tracks
// pending/in-service state and supplies the vector during acknowledge.
module z80_int_ctrl
    import z80mini_pkg::*;
#(
    parameter int unsigned NUM_SRC   = 4,
    parameter logic [6:0]  EDGE_MASK = 7'h7F,
    parameter logic [7:0]  VEC_BASE  = 8'h00
) (
    input logic               clk,
    input logic               n_res,
    z80_int_ctrl_if.slave     bus
);
    localparam logic [NUM_SRC-1:0] EDGE     = EDGE_MASK[NUM_SRC-1:0];
    localparam logic [7:0]         BASE_RST = VEC_BASE & 8'hF0;

    logic [NUM_SRC-1:0] irq_s1, irq_s2, irq_s3;
    logic               inta_s1, inta_s2, inta_s3;
    logic [NUM_SRC-1:0] mask, pend, isr;
    logic [7:0]         base;
    ack_state_t         state;
    logic [2:0]         win;

    logic [NUM_SRC-1:0] irq_rise, below, eligible, ack_hit;
    logic [NUM_SRC-1:0] pend_next, isr_next, wdata;
    logic               inta_fall, isr_any, elig_any;
    logic [2:0]         isr_top, elig_idx;
    logic               wr_mask, wr_pend, wr_isr, wr_base;
    logic               unused_rd;

    // Reads have no side effects, so the read strobe is not needed.
    assign unused_rd = bus.io_rd;

    assign irq_rise  = irq_s2 & ~irq_s3;
    assign inta_fall = ~inta_s2 & inta_s3;
    assign wdata     = bus.din[NUM_SRC-1:0];
    assign wr_mask   = bus.io_wr && (bus.addr == REG_MASK);
    assign wr_pend   = bus.io_wr && (bus.addr == REG_PEND);
    assign wr_isr    = bus.io_wr && (bus.addr == REG_ISR);
    assign wr_base   = bus.io_wr && (bus.addr == REG_BASE);

    z80_prio_enc #(.W(NUM_SRC)) u_ceil (
        .req   (isr),
        .found (isr_any),
        .idx   (isr_top)
    );

    always_comb begin
        below = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++)
            below[i] = !isr_any || (3'(i) < isr_top);
    end

    assign eligible = pend & mask & below;

    z80_prio_enc #(.W(NUM_SRC)) u_win (
        .req   (eligible),
        .found (elig_any),
        .idx   (elig_idx)
    );

    // Spurious acks latch win=7, which matches no source bit.
    always_comb begin
        ack_hit = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++)
            ack_hit[i] = (state == ACK_ACK) && (win == 3'(i));
    end

    always_comb begin
        pend_next = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (EDGE[i])
                pend_next[i] = irq_rise[i] |
                               (pend[i] & ~ack_hit[i] & ~(wr_pend & wdata[i]));
            else
                pend_next[i] = irq_s2[i];
        end
    end

    assign isr_next = (isr & ~(wr_isr ? wdata : '0)) | ack_hit;

    always_ff @(posedge clk or negedge n_res) begin
        if (!n_res) begin
            irq_s1  <= '0;
            irq_s2  <= '0;
            irq_s3  <= '0;
            inta_s1 <= 1'b1;
            inta_s2 <= 1'b1;
            inta_s3 <= 1'b1;
            mask    <= '0;
            pend    <= '0;
            isr     <= '0;
            base    <= BASE_RST;
        end else begin
            irq_s1  <= bus.irq;
            irq_s2  <= irq_s1;
            irq_s3  <= irq_s2;
            inta_s1 <= bus.n_inta;
            inta_s2 <= inta_s1;
            inta_s3 <= inta_s2;
            pend    <= pend_next;
            isr     <= isr_next;
            if (wr_mask) mask <= wdata;
            if (wr_base) base <= {bus.din[7:4], 4'h0};
        end
    end

    always_ff @(posedge clk or negedge n_res) begin
        if (!n_res) begin
            state     <= ACK_IDLE;
            win       <= '0;
            bus.vec   <= BASE_RST;
            bus.n_int <= 1'b1;
        end else begin
            bus.n_int <= ~elig_any;
            case (state)
                ACK_IDLE: begin
                    if (inta_fall) begin
                        win   <= elig_any ? elig_idx : SPURIOUS_IDX;
                        state <= ACK_ACK;
                    end
                end
                ACK_ACK: begin
                    bus.vec   <= base | {4'h0, win, 1'b0};
                    bus.n_int <= 1'b1;
                    state     <= ACK_HOLD;
                end
                ACK_HOLD: begin
                    if (inta_s2) state <= ACK_IDLE;
                end
                default: state <= ACK_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.dout = '0;
        case (bus.addr)
            REG_MASK: bus.dout = 8'(mask);
            REG_PEND: bus.dout = 8'(pend);
            REG_ISR:  bus.dout = 8'(isr);
            REG_BASE: bus.dout = base;
            default:  bus.dout = '0;
        endcase
    end
endmodule

// File: tb/tb_z80_int_ctrl.sv
// Self-checking bench for z80_int_ctrl: directed scenarios plus a randomised
// transaction run against a register-level reference model.
module tb_z80_int_ctrl;
    localparam logic [3:0] EDGE4 = 4'b0111;

    logic clk = 1'b0;
    logic n_res = 1'b0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [3:0] m_mask, m_pend, m_isr;
    logic       m_lvl;
    logic [7:0] m_base;

    z80_int_ctrl_if #(.NUM_SRC(4)) bus ();

    z80_int_ctrl #(
        .NUM_SRC   (4),
        .EDGE_MASK (7'h77),
        .VEC_BASE  (8'h00)
    ) dut (
        .clk   (clk),
        .n_res (n_res),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.addr  = a;
        bus.din   = d;
        bus.io_wr = 1'b1;
        tick(1);
        bus.io_wr = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        bus.addr  = a;
        bus.io_rd = 1'b1;
        #1;
        d = bus.dout;
        bus.io_rd = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] bits);
        bus.irq = bus.irq | bits;
        tick(3);
        bus.irq = bus.irq & ~bits;
        tick(4);
    endtask

    task automatic do_ack(output logic [7:0] v);
        bus.n_inta = 1'b0;
        tick(6);
        v = bus.vec;
        bus.n_inta = 1'b1;
        tick(4);
    endtask

    function automatic logic [3:0] m_pend_rd();
        return (m_pend & EDGE4) | {m_lvl, 3'b000};
    endfunction

    function automatic logic [3:0] m_elig();
        int unsigned ceil_i = 4;
        for (int i = 3; i >= 0; i--)
            if (m_isr[i]) ceil_i = i;
        return m_pend_rd() & m_mask & 4'((1 << ceil_i) - 1);
    endfunction

    task automatic test_reset();
        logic [7:0] d;
        bus.irq = '0; bus.n_inta = 1'b1; bus.io_wr = 1'b0; bus.io_rd = 1'b0;
        bus.addr = '0; bus.din = '0;
        n_res = 1'b0;
        tick(3);
        n_res = 1'b1;
        tick(2);
        n_cmp++; if (bus.n_int !== 1'b1) begin n_bad++; $display("FAIL reset_n_int got %b want 1", bus.n_int); end
        n_cmp++; if (bus.vec !== 8'h00) begin n_bad++; $display("FAIL reset_vec got %h want 00", bus.vec); end
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL reset_reg%0d got %h want 00", a, d); end
        end
    endtask

    task automatic test_basic_ack();
        logic [7:0] d, v;
        wr(2'd0, 8'h0F);
        bus.irq[1] = 1'b1;
        tick(3);
        n_cmp++; if (bus.n_int !== 1'b1) begin n_bad++; $display("FAIL lat3_n_int got %b want 1", bus.n_int); end
        rd(2'd1, d);
        n_cmp++; if (d !== 8'h02) begin n_bad++; $display("FAIL lat3_pend got %h want 02", d); end
        tick(1);
        n_cmp++; if (bus.n_int !== 1'b0) begin n_bad++; $display("FAIL lat4_n_int got %b want 0", bus.n_int); end
        bus.irq[1] = 1'b0;
        do_ack(v);
        n_cmp++; if (v !== 8'h02) begin n_bad++; $display("FAIL basic_vec got %h want 02", v); end
        rd(2'd2, d);
        n_cmp++; if (d !== 8'h02) begin n_bad++; $display("FAIL basic_isr got %h want 02", d); end
        rd(2'd1, d);
        n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL basic_pend got %h want 00", d); end
        wr(2'd2, 8'h02);
    endtask

    task automatic test_simultaneous();
        logic [7:0] v;
        wr(2'd3, 8'hF7);
        pulse(4'b0101);
        n_cmp++; if (bus.n_int !== 1'b0) begin n_bad++; $display("FAIL simul_n_int got %b want 0", bus.n_int); end
        do_ack(v);
        n_cmp++; if (v !== 8'hF0) begin n_bad++; $display("FAIL simul_vec1 got %h want F0", v); end
        n_cmp++; if (bus.n_int !== 1'b1) begin n_bad++; $display("FAIL simul_blocked got %b want 1", bus.n_int); end
        wr(2'd2, 8'h01);
        tick(2);
        n_cmp++; if (bus.n_int !== 1'b0) begin n_bad++; $display("FAIL simul_eoi got %b want 0", bus.n_int); end
        do_ack(v);
        n_cmp++; if (v !== 8'hF4) begin n_bad++; $display("FAIL simul_vec2 got %h want F4", v); end
    endtask

    task automatic test_nesting();
        logic [7:0] d, v;
        pulse(4'b0001);
        n_cmp++; if (bus.n_int !== 1'b0) begin n_bad++; $display("FAIL nest_n_int got %b want 0", bus.n_int); end
        do_ack(v);
        n_cmp++; if (v !== 8'hF0) begin n_bad++; $display("FAIL nest_vec got %h want F0", v); end
        rd(2'd2, d);
        n_cmp++; if (d !== 8'h05) begin n_bad++; $display("FAIL nest_isr got %h want 05", d); end
        wr(2'd2, 8'h01);
        bus.irq[3] = 1'b1;
        tick(6);
        n_cmp++; if (bus.n_int !== 1'b1) begin n_bad++; $display("FAIL nest_lower got %b want 1", bus.n_int); end
        wr(2'd2, 8'h04);
        tick(2);
        n_cmp++; if (bus.n_int !== 1'b0) begin n_bad++; $display("FAIL nest_unblock got %b want 0", bus.n_int); end
        bus.irq[3] = 1'b0;
        tick(6);
        n_cmp++; if (bus.n_int !== 1'b1) begin n_bad++; $display("FAIL nest_level_drop got %b want 1", bus.n_int); end
    endtask

    task automatic test_mask();
        logic [7:0] d, v;
        wr(2'd0, 8'h00);
        pulse(4'b0010);
        rd(2'd1, d);
        n_cmp++; if (d !== 8'h02) begin n_bad++; $display("FAIL mask_pend got %h want 02", d); end
        n_cmp++; if (bus.n_int !== 1'b1) begin n_bad++; $display("FAIL mask_n_int got %b want 1", bus.n_int); end
        wr(2'd0, 8'h02);
        n_cmp++; if (bus.n_int !== 1'b1) begin n_bad++; $display("FAIL mask_1clk got %b want 1", bus.n_int); end
        tick(1);
        n_cmp++; if (bus.n_int !== 1'b0) begin n_bad++; $display("FAIL mask_2clk got %b want 0", bus.n_int); end
        do_ack(v);
        n_cmp++; if (v !== 8'hF2) begin n_bad++; $display("FAIL mask_vec got %h want F2", v); end
        wr(2'd2, 8'h02);
    endtask

    task automatic test_spurious_level();
        logic [7:0] d, v;
        do_ack(v);
        n_cmp++; if (v !== 8'hFE) begin n_bad++; $display("FAIL spur_vec got %h want FE", v); end
        rd(2'd2, d);
        n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL spur_isr got %h want 00", d); end
        bus.irq[3] = 1'b1;
        tick(4);
        wr(2'd1, 8'h08);
        tick(2);
        rd(2'd1, d);
        n_cmp++; if (d !== 8'h08) begin n_bad++; $display("FAIL level_w1c got %h want 08", d); end
        bus.irq[3] = 1'b0;
        tick(4);
        rd(2'd1, d);
        n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL level_drop got %h want 00", d); end
    endtask

    task automatic test_reset_in_hold();
        logic [7:0] d, v;
        wr(2'd0, 8'h0F);
        pulse(4'b0010);
        bus.n_inta = 1'b0;
        tick(6);
        n_res = 1'b0;
        #2;
        n_cmp++; if (bus.n_int !== 1'b1) begin n_bad++; $display("FAIL rst_hold_n_int got %b want 1", bus.n_int); end
        n_cmp++; if (bus.vec !== 8'h00) begin n_bad++; $display("FAIL rst_hold_vec got %h want 00", bus.vec); end
        for (int a = 0; a < 3; a++) begin
            rd(2'(a), d);
            n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL rst_hold_reg%0d got %h want 00", a, d); end
        end
        bus.n_inta = 1'b1;
        tick(2);
        n_res = 1'b1;
        tick(2);
        wr(2'd0, 8'h0F);
        pulse(4'b0100);
        do_ack(v);
        n_cmp++; if (v !== 8'h04) begin n_bad++; $display("FAIL rst_after_vec got %h want 04", v); end
        rd(2'd2, d);
        n_cmp++; if (d !== 8'h04) begin n_bad++; $display("FAIL rst_after_isr got %h want 04", d); end
    endtask

    task automatic test_random();
        logic [7:0] d, v, ev;
        logic [3:0] el;
        int unsigned op, src, w;
        n_res = 1'b0;
        tick(2);
        n_res = 1'b1;
        tick(2);
        m_mask = '0; m_pend = '0; m_isr = '0; m_lvl = 1'b0; m_base = 8'h00;
        for (int it = 0; it < 80; it++) begin
            op = $urandom_range(0, 5);
            d  = 8'($urandom);
            case (op)
                0: begin
                    src = $urandom_range(0, 3);
                    if (src == 3) begin
                        m_lvl = 1'($urandom_range(0, 1));
                        bus.irq[3] = m_lvl;
                    end else begin
                        pulse(4'(1 << src));
                        m_pend[src] = 1'b1;
                    end
                end
                1: begin wr(2'd0, d); m_mask = d[3:0]; end
                2: begin wr(2'd1, d); m_pend = m_pend & ~(d[3:0] & EDGE4); end
                3: begin wr(2'd2, d); m_isr = m_isr & ~d[3:0]; end
                4: begin
                    el = m_elig();
                    ev = m_base | 8'h0E;
                    for (int i = 3; i >= 0; i--) begin
                        if (el[i]) ev = m_base | 8'(i * 2);
                    end
                    do_ack(v);
                    n_cmp++; if (v !== ev) begin n_bad++; $display("FAIL rand_vec it%0d got %h want %h", it, v, ev); end
                    if (el != 0) begin
                        w = (ev[3:0]) >> 1;
                        m_isr[w] = 1'b1;
                        if (EDGE4[w]) m_pend[w] = 1'b0;
                    end
                end
                default: begin wr(2'd3, d); m_base = d & 8'hF0; end
            endcase
            tick(6);
            rd(2'd0, d);
            n_cmp++; if (d !== {4'h0, m_mask}) begin n_bad++; $display("FAIL rand_mask it%0d got %h want %h", it, d, m_mask); end
            rd(2'd1, d);
            n_cmp++; if (d !== {4'h0, m_pend_rd()}) begin n_bad++; $display("FAIL rand_pend it%0d got %h want %h", it, d, m_pend_rd()); end
            rd(2'd2, d);
            n_cmp++; if (d !== {4'h0, m_isr}) begin n_bad++; $display("FAIL rand_isr it%0d got %h want %h", it, d, m_isr); end
            rd(2'd3, d);
            n_cmp++; if (d !== m_base) begin n_bad++; $display("FAIL rand_base it%0d got %h want %h", it, d, m_base); end
            n_cmp++; if (bus.n_int !== (m_elig() == 0)) begin n_bad++; $display("FAIL rand_n_int it%0d got %b want %b", it, bus.n_int, m_elig() == 0); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_ack();
        test_simultaneous();
        test_nesting();
        test_mask();
        test_spurious_level();
        test_reset_in_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/z80_int_ctrl.md
Name: z80_int_ctrl

Overview:
Prioritising interrupt controller for the z80mini glue logic. It arbitrates up to seven requesters (PS/2 receiver, 8251 console, timer, expansion) onto the single Z80 nINT line. It supplies the IM2 vector during the interrupt-acknowledge cycle and tracks in-service state so that a higher-priority source can nest over a lower one. The CPU programs it through four I/O registers decoded by the top level.

Parameters:
NUM_SRC, 4, number of interrupt sources, 1..7; index 0 has the highest priority.
EDGE_MASK, 7'h7F, per source: 1 = rising-edge triggered, 0 = level (active-high).
VEC_BASE, 8'h00, reset value of the vector base register; bits [3:0] are ignored.

Ports:
clk  in  1  CPU clock (CPUCLK).
n_res  in  1  asynchronous active-low reset.
irq  in  NUM_SRC  raw, asynchronous interrupt requests.
n_inta  in  1  low while nM1=0 and nIORQ=0, level, asynchronous.
io_wr  in  1  one-clk write strobe, already decoded for this block's ports.
io_rd  in  1  one-clk read strobe.
addr  in  2  register select.
din  in  8  write data.
dout  out  8  read data (combinational mux of addr).
n_int  out  1  registered interrupt request to the CPU, active-low.
vec  out  8  IM2 vector, held stable while n_inta is low.

Behaviour:
- Reset state (asynchronous): mask=8'h00 (all sources masked), pend=0, isr=0, base=VEC_BASE&8'hF0, n_int=1, vec=base. dout follows the register mux; it is not reset.
- Input synchronisers: irq and n_inta each pass through a 2-FF synchroniser, then an edge detect. Pending latency from an irq rise to the pend bit is 3 clk. n_int falls 1 clk after that (4 clk total).
- Edge sources: pend[i] sets on a synchronised rising edge. It clears on acknowledge of source i, or on a write of 1 to PEND bit i. If a set and a clear occur in the same clk, set wins.
- Level sources: pend[i] equals the synchronised irq[i]. PEND writes have no effect on these bits.
- Eligibility: a source is eligible when pend&mask is set and its index is lower than the lowest set isr index. isr=0 means every source is eligible.
- n_int is 0 whenever any source is eligible, re-evaluated every clk and registered.
- Ack state machine, states IDLE -> ACK -> HOLD -> IDLE:
  - IDLE: on a synchronised falling edge of n_inta, latch win = lowest eligible index. If nothing is eligible (spurious), latch win=7.
  - ACK (1 clk): vec <= base | {win,1'b0}. isr[win] <= 1, except for spurious. pend[win] <= 0 for edge sources. n_int is forced to 1 this clk.
  - HOLD: stay until synchronised n_inta is 1, then return to IDLE. vec holds its value throughout.
- Registers:
  - addr 0 MASK, R/W, 1 = enabled.
  - addr 1 PEND, R; W1C for edge sources.
  - addr 2 ISR, R; W1C. Writing a 1 is end-of-interrupt.
  - addr 3 BASE, R/W, bits [3:0] read back as 0.
  - Bits at or above NUM_SRC read 0 and ignore writes.
- Simultaneous events: an ack-driven update of isr/pend has priority over a W1C write on the same bit in the same clk. A MASK write takes effect on the next clk's eligibility.
- Reset asserted mid-acknowledge returns to IDLE with the reset values; vec returns to the reset base.

Decomposition:
- Shared package z80mini_pkg:
  - register address constants REG_MASK=0, REG_PEND=1, REG_ISR=2, REG_BASE=3;
  - SPURIOUS_IDX=3'd7;
  - ack state enum.
- One sub-module, z80_prio_enc: a parameterised lowest-index-first priority encoder returning {found, idx[2:0]}. It is used for both winner selection and the isr ceiling.

Test Plan:
- Reset, then MASK=0x0F, then pulse irq[1] -> n_int=0 4 clk after the rise. Pull n_inta low -> vec=0x02, ISR reads 0x02, PEND reads 0x00.
- BASE=0xF0, irq[2] and irq[0] rise in the same clk -> first ack gives vec=0xF0. Second ack is blocked (n_int=1) until ISR is written 0x01. The following ack gives vec=0xF4.
- Nesting: source 2 in service, irq[0] rises -> n_int=0 and ack vec=base|0x00, ISR=0x05. irq[3] rises while source 2 is in service -> n_int stays 1.
- MASK=0x00, irq[1] rises -> PEND=0x02 and n_int=1. Write MASK=0x02 -> n_int=0 2 clk later.
- Spurious: n_inta low with nothing eligible -> vec=base|0x0E and ISR unchanged. Level source (EDGE_MASK bit 3=0) held high -> a PEND write of 0x08 leaves PEND=0x08.
- Assert n_res while in HOLD -> n_int=1, MASK/PEND/ISR=0, and the block acks normally after release.
